core_rf_sb: RTL

CORE_RF_SB -- requirements
Module: core_rf_sb

---
 rtl/core_rf_sb.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/core_rf_sb.sv
// Multi-ported register file with a busy scoreboard and a sequential full-array clear.
// Define RF_SB_BYPASS_EN to forward same-cycle write data to the read ports.
module core_rf_sb #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 16,
  parameter int R_PORTS  = 4,
  parameter int W_PORTS  = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk_i,
  input  logic                        arst_ni,
  input  logic [R_PORTS*$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [R_PORTS*DATA_W-1:0]   rd_data_o,
  output logic [R_PORTS-1:0]          rd_busy_o,
  input  logic [W_PORTS-1:0]          wr_en_i,
  input  logic [W_PORTS*$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [W_PORTS*DATA_W-1:0]   wr_data_i,
  input  logic                        alloc_en_i,
  input  logic [$clog2(DEPTH)-1:0]    alloc_addr_i,
  input  logic                        clr_req_i,
  output logic                        clr_busy_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

  state_e            state_q;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [AW-1:0]     waddr_s;

  assign clr_busy_o = (state_q == ST_CLEAR);

  // Next array state: clear one entry, or apply writes (highest port last) then alloc.
  always_comb begin
    mem_d   = mem_q;
    busy_d  = busy_q;
    waddr_s = '0;
    if (state_q == ST_CLEAR) begin
      mem_d[idx_q]  = '0;
      busy_d[idx_q] = 1'b0;
    end else begin
      for (int w = 0; w < W_PORTS; w++) begin
        waddr_s = wr_addr_i[w*AW +: AW];
        if (wr_en_i[w] && !(ZERO_REG != 0 && waddr_s == '0)) begin
          mem_d[waddr_s]  = wr_data_i[w*DATA_W +: DATA_W];
          busy_d[waddr_s] = 1'b0;
        end else begin
          busy_d = busy_d;
        end
      end
      if (alloc_en_i && !(ZERO_REG != 0 && alloc_addr_i == '0)) begin
        busy_d[alloc_addr_i] = 1'b1;
      end else begin
        busy_d = busy_d;
      end
    end
  end

  // Array and scoreboard storage.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  // Clear sequencer; idx wraps back to 0 on the final clear edge.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clr_req_i) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
          end
        end
        ST_CLEAR: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == AW'(DEPTH - 1)) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  for (genvar p = 0; p < R_PORTS; p++) begin : g_rd
    logic [AW-1:0]     ra_s;
    logic [DATA_W-1:0] data_s;
    logic              busy_s;
    logic              hit_s;

    assign ra_s = rd_addr_i[p*AW +: AW];

    // Combinational read with optional forwarding and zero-register masking.
    always_comb begin
      data_s = mem_q[ra_s];
      busy_s = busy_q[ra_s];
      hit_s  = 1'b0;
`ifdef RF_SB_BYPASS_EN
      if (state_q == ST_IDLE) begin
        for (int w = 0; w < W_PORTS; w++) begin
          if (wr_en_i[w] && wr_addr_i[w*AW +: AW] == ra_s) begin
            data_s = wr_data_i[w*DATA_W +: DATA_W];
            busy_s = 1'b0;
            hit_s  = 1'b1;
          end else begin
            hit_s = hit_s;
          end
        end
        if (hit_s && alloc_en_i && alloc_addr_i == ra_s) begin
          busy_s = 1'b1;
        end else begin
          busy_s = busy_s;
        end
      end else begin
        hit_s = 1'b0;
      end
`endif
      if (ZERO_REG != 0 && ra_s == '0) begin
        data_s = '0;
        busy_s = 1'b0;
      end else begin
        data_s = data_s;
      end
    end

    assign rd_data_o[p*DATA_W +: DATA_W] = data_s;
    assign rd_busy_o[p]                  = busy_s;
  end

endmodule
